load_store_unit: RTL

- Initiator side of the data-memory interface: sits between the datapath and the word-addressed data memory.
- Accepts byte-addressed load/store requests (byte, half, word; signed/unsigned loads) and drives the memory's address/writeData/memWrite/memRead.
- Sub-word stores use read-modify-write, because the memory stores whole words only.
- Little-endian byte lanes, alignment and range checking, one-request-at-a-time handshake.

---
 rtl/load_store_unit.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Initiator side of the data-memory interface. Takes one byte-addressed
// load/store request at a time from the datapath and drives the word-addressed
// data memory. Sub-word stores are done as read-modify-write because the
// memory only stores whole words. Byte lanes are little-endian.
//
// Ports
//   clock       rising-edge system clock
//   reset       asynchronous, active-high reset
//   req         request strobe, sampled only while ready=1
//   store       1 = store, 0 = load
//   size        00 byte, 01 half, 10 word, 11 illegal
//   isUnsigned  loads: 1 = zero-extend, 0 = sign-extend
//   byteAddr    byte address of the access
//   storeData   store value, right-aligned for byte/half
//   ready       high only while idle
//   done        one-cycle completion pulse
//   error       valid with done, held until the next accepted request
//   loadData    extended load result, held until the next successful load
//   address     word index to memory (byteAddr[31:2], zero-extended)
//   writeData   word written to memory
//   memWrite    memory write enable
//   memRead     memory read enable
//   readData    memory read word (combinational, same cycle as memRead)
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int data_width    = 32,
  parameter int address_width = 32,
  parameter int memory_size   = 128
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     store,
  input  logic [1:0]               size,
  input  logic                     isUnsigned,
  input  logic [address_width-1:0] byteAddr,
  input  logic [data_width-1:0]    storeData,
  output logic                     ready,
  output logic                     done,
  output logic                     error,
  output logic [data_width-1:0]    loadData,
  output logic [address_width-1:0] address,
  output logic [data_width-1:0]    writeData,
  output logic                     memWrite,
  output logic                     memRead,
  input  logic [data_width-1:0]    readData
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  localparam logic [address_width-1:0] MEM_WORDS = address_width'(memory_size);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Acceptance check; illegal size wins over misalignment, which wins over range.
  function automatic logic req_error(input logic [1:0]               sz,
                                     input logic [address_width-1:0] addr);
    logic                     err;
    logic [address_width-1:0] word_idx;
    word_idx = {2'b00, addr[address_width-1:2]};
    if (sz == SZ_BAD) begin
      err = 1'b1;
    end else if ((sz == SZ_HALF) && addr[0]) begin
      err = 1'b1;
    end else if ((sz == SZ_WORD) && (addr[1:0] != 2'b00)) begin
      err = 1'b1;
    end else if (word_idx >= MEM_WORDS) begin
      err = 1'b1;
    end else begin
      err = 1'b0;
    end
    return err;
  endfunction

  // Pick the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  lane,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    if (lane[1]) begin
      h = word[31:16];
    end else begin
      h = word[15:0];
    end
    case (sz)
      SZ_BYTE: r = {{24{~uns & b[7]}}, b};
      SZ_HALF: r = {{16{~uns & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the target lane of the captured word with the store value.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  lane,
                                              input logic [31:0] data);
    logic [31:0] r;
    r = word;
    if (sz == SZ_BYTE) begin
      case (lane)
        2'd0:    r[7:0]   = data[7:0];
        2'd1:    r[15:8]  = data[7:0];
        2'd2:    r[23:16] = data[7:0];
        2'd3:    r[31:24] = data[7:0];
        default: r        = word;
      endcase
    end else begin
      if (lane[1]) begin
        r[31:16] = data[15:0];
      end else begin
        r[15:0] = data[15:0];
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State and request latches
  // ---------------------------------------------------------------------------
  state_t                   state_q,  state_d;
  logic                     store_q,  store_d;
  logic [1:0]               size_q,   size_d;
  logic                     uns_q,    uns_d;
  logic [address_width-1:0] addr_q,   addr_d;
  logic [data_width-1:0]    sdata_q,  sdata_d;
  logic [data_width-1:0]    merge_q,  merge_d;
  logic                     error_q,  error_d;
  logic [data_width-1:0]    load_q,   load_d;

  logic                     req_err_s;

  // Error classification of the request currently presented on the inputs.
  always_comb begin
    req_err_s = req_error(size, byteAddr);
  end

  // Next-state logic: request capture, lane extraction and merge.
  always_comb begin
    state_d = state_q;
    store_d = store_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    merge_d = merge_q;
    error_d = error_q;
    load_d  = load_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          store_d = store;
          size_d  = size;
          uns_d   = isUnsigned;
          addr_d  = byteAddr;
          sdata_d = storeData;
          error_d = req_err_s;
          if (req_err_s) begin
            state_d = ST_DONE;
          end else if (store && (size == SZ_WORD)) begin
            // Whole-word stores need no read of the old contents.
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (store_q) begin
          merge_d = store_merge(readData, size_q, addr_q[1:0], sdata_q);
          state_d = ST_WRITE;
        end else begin
          load_d  = load_extend(readData, size_q, addr_q[1:0], uns_q);
          state_d = ST_DONE;
        end
      end
      ST_WRITE: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latch registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      store_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      sdata_q <= '0;
      merge_q <= '0;
      error_q <= 1'b0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      merge_q <= merge_d;
      error_q <= error_d;
      load_q  <= load_d;
    end
  end

  // Memory-side and handshake outputs, decoded purely from registered state
  // so that reset removes any in-flight read or write immediately.
  always_comb begin
    ready     = 1'b0;
    done      = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    address   = '0;
    writeData = '0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
      end
      ST_READ: begin
        memRead = 1'b1;
        address = {2'b00, addr_q[address_width-1:2]};
      end
      ST_WRITE: begin
        memWrite = 1'b1;
        address  = {2'b00, addr_q[address_width-1:2]};
        if (size_q == SZ_WORD) begin
          writeData = sdata_q;
        end else begin
          writeData = merge_q;
        end
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  assign error    = error_q;
  assign loadData = load_q;

endmodule
